// File: rtl/mac_seq_counter.sv
// Run-length tap sequencer for the MAC datapath: counts a programmed number of enabled cycles per run.
// Latency: start -> busy/count_out=0 one edge later; done pulses one cycle after the terminal enabled edge.
// Backpressure: count_enb stalls the count cycle-for-cycle; count_reset aborts from any state without done.
//
// Ports:
//   clk_out      sole clock, rising edge
//   rst          synchronous active-high reset
//   start        request a run (sampled in IDLE, and in DONE when auto-restart is built in)
//   length       taps per run, latched at run start; 0 means 2^WIDTH
//   count_enb    advance the tap index while running
//   count_reset  abort: back to IDLE with count_out=0, no done pulse
//   count_out    current tap index
//   busy         high while running
//   last         high while running on the terminal tap (count_out == len_q-1 mod 2^WIDTH)
//   done         one-cycle pulse after the terminal enabled edge
//
// Build option: define MAC_SEQ_AUTO_RESTART_EN to let a start seen in DONE go straight back to RUN.
module mac_seq_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk_out,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] length,
    input  logic             count_enb,
    input  logic             count_reset,
    output logic [WIDTH-1:0] count_out,
    output logic             busy,
    output logic             last,
    output logic             done
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [WIDTH-1:0] len_q;
    logic [WIDTH-1:0] len_d;
    logic [WIDTH-1:0] cnt_d;
    logic [WIDTH-1:0] len_m1;

    // Wraps to all-ones for length 0, which gives the full 2^WIDTH-tap run.
    assign len_m1 = len_q - WIDTH'(1);
    assign last   = (state_q == ST_RUN) && (count_out == len_m1);

    always_comb begin
        state_d = state_q;
        cnt_d   = count_out;
        len_d   = len_q;
        if (count_reset) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_d = '0;
                    if (start) begin
                        state_d = ST_RUN;
                        len_d   = length;
                    end
                end
                ST_RUN: begin
                    if (count_enb) begin
                        if (last) begin
                            // Terminal tap: hold len_q-1 on count_out through DONE.
                            state_d = ST_DONE;
                        end else begin
                            cnt_d = count_out + WIDTH'(1);
                        end
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
`ifdef MAC_SEQ_AUTO_RESTART_EN
                    if (start) begin
                        state_d = ST_RUN;
                        len_d   = length;
                    end
`endif
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // busy/done are registered copies of the next state so they line up with count_out.
    always_ff @(posedge clk_out) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            count_out <= '0;
            len_q     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_out <= cnt_d;
            len_q     <= len_d;
            busy      <= (state_d == ST_RUN);
            done      <= (state_d == ST_DONE);
        end
    end

endmodule
